// File: rtl/uart_trig_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_trig_cmd_ctrl
//
// Frame controller between a UART byte receiver/transmitter and four trigger
// channel registers. Command frames are four bytes: HDR, channel, type, value.
// A complete frame writes the addressed channel's threshold and trigger type
// and is answered with ACK_BYTE. A frame with a bad channel or type is
// answered with NAK_BYTE. A frame stalled longer than TIMEOUT_CYC cycles
// between bytes is dropped silently and counted as an error.
//
// Ports
//   clk, nrst            clock (rising edge), asynchronous active-low reset
//   rx_data, rx_valid    received byte plus one-cycle strobe (no backpressure)
//   tx_data, tx_valid,   reply byte handshake (see below)
//   tx_ready
//   trigout_ch0..3       per-channel trigger value registers
//   trig_type            2 bits per channel, [2n+1:2n] = ch n, 2'b11 = no trigger
//   trig_upd             one-cycle pulse per channel after its registers change
//   busy                 high whenever the parser is not idle
//   err_cnt              rejected + timed-out frames, saturating at 8'hFF
//
// TX handshake: tx_valid rises when a reply is pending and, together with
// tx_data, stays unchanged until a rising clk edge sees tx_valid & tx_ready;
// that edge transfers the byte, and tx_valid falls right after it. tx_valid
// never depends combinationally on tx_ready.
// ---------------------------------------------------------------------------
module uart_trig_cmd_ctrl #(
  parameter logic [7:0]      HDR_BYTE    = 8'h53,
  parameter logic [7:0]      ACK_BYTE    = 8'h06,
  parameter logic [7:0]      NAK_BYTE    = 8'h15,
  parameter int              TO_W        = 20,
  parameter logic [TO_W-1:0] TIMEOUT_CYC = 20'd125000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] trigout_ch0,
  output logic [7:0] trigout_ch1,
  output logic [7:0] trigout_ch2,
  output logic [7:0] trigout_ch3,
  output logic [7:0] trig_type,
  output logic [3:0] trig_upd,
  output logic       busy,
  output logic [7:0] err_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHAN  = 3'd1,
    ST_TYPE  = 3'd2,
    ST_VALUE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam bit              TO_EN   = (TIMEOUT_CYC != '0);
  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CYC - 1'b1;

  state_t          state_q, state_d;
  logic [1:0]      ch_q, ch_d;
  logic [1:0]      type_q, type_d;
  logic            nak_q, nak_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      trig_q [4];
  logic [7:0]      trig_d [4];
  logic [7:0]      trig_type_q, trig_type_d;
  logic [3:0]      trig_upd_q, trig_upd_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic in_frame;
  logic to_hit;
  logic resp_done;
  logic err_inc;

  // The timeout only runs while a frame is half received; a byte on the
  // expiry edge takes priority over the timeout.
  assign in_frame  = (state_q == ST_CHAN) || (state_q == ST_TYPE) ||
                     (state_q == ST_VALUE);
  assign to_hit    = TO_EN && in_frame && !rx_valid && (to_cnt_q == TO_LAST);
  assign resp_done = (state_q == ST_RESP) && tx_ready;
  // A NAK is only counted once it has actually been handed to TX.
  assign err_inc   = to_hit || (resp_done && nak_q);

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    type_d      = type_q;
    nak_d       = nak_q;
    to_cnt_d    = '0;
    trig_d      = trig_q;
    trig_type_d = trig_type_q;
    trig_upd_d  = '0;
    err_cnt_d   = err_cnt_q;

    if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    if (TO_EN && in_frame && !rx_valid && !to_hit) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == HDR_BYTE)) begin
          state_d = ST_CHAN;
        end
      end
      ST_CHAN: begin
        if (rx_valid) begin
          if (rx_data <= 8'd3) begin
            ch_d    = rx_data[1:0];
            state_d = ST_TYPE;
          end else begin
            nak_d   = 1'b1;
            state_d = ST_RESP;
          end
        end else if (to_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_TYPE: begin
        if (rx_valid) begin
          if (rx_data <= 8'd2) begin
            type_d  = rx_data[1:0];
            state_d = ST_VALUE;
          end else begin
            nak_d   = 1'b1;
            state_d = ST_RESP;
          end
        end else if (to_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_VALUE: begin
        if (rx_valid) begin
          trig_d[ch_q]                       = rx_data;
          trig_type_d[{ch_q, 1'b0} +: 2]     = type_q;
          trig_upd_d[ch_q]                   = 1'b1;
          nak_d                              = 1'b0;
          state_d                            = ST_RESP;
        end else if (to_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        // Incoming bytes are dropped here, including a new header.
        if (tx_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      type_q      <= '0;
      nak_q       <= 1'b0;
      to_cnt_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        trig_q[i] <= '0;
      end
      trig_type_q <= 8'hFF;
      trig_upd_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      type_q      <= type_d;
      nak_q       <= nak_d;
      to_cnt_q    <= to_cnt_d;
      trig_q      <= trig_d;
      trig_type_q <= trig_type_d;
      trig_upd_q  <= trig_upd_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Reply outputs decode straight from flops, so they hold steady while
  // the reply waits for tx_ready.
  assign tx_valid    = (state_q == ST_RESP);
  assign tx_data     = tx_valid ? (nak_q ? NAK_BYTE : ACK_BYTE) : 8'h00;
  assign busy        = (state_q != ST_IDLE);
  assign trigout_ch0 = trig_q[0];
  assign trigout_ch1 = trig_q[1];
  assign trigout_ch2 = trig_q[2];
  assign trigout_ch3 = trig_q[3];
  assign trig_type   = trig_type_q;
  assign trig_upd    = trig_upd_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_uart_trig_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_trig_cmd_ctrl
//
// Self-checking bench for uart_trig_cmd_ctrl. A table of frames with
// hand-derived expected register state is applied in a loop; hand-written
// sequences cover update latency, reply stall, back-to-back frames, the
// inter-byte timeout, reset mid-frame / mid-reply and err_cnt saturation.
// Expected reply bytes go into exp_q when a frame is driven and are popped
// by the TX monitor when the DUT hands a reply over.
// ---------------------------------------------------------------------------
module tb_uart_trig_cmd_ctrl;

  localparam int TO = 40;

  logic       clk;
  logic       nrst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] trigout_ch0, trigout_ch1, trigout_ch2, trigout_ch3;
  logic [7:0] trig_type;
  logic [3:0] trig_upd;
  logic       busy;
  logic [7:0] err_cnt;

  uart_trig_cmd_ctrl #(
    .TO_W        (20),
    .TIMEOUT_CYC (20'd40)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .trigout_ch0 (trigout_ch0),
    .trigout_ch1 (trigout_ch1),
    .trigout_ch2 (trigout_ch2),
    .trigout_ch3 (trigout_ch3),
    .trig_type   (trig_type),
    .trig_upd    (trig_upd),
    .busy        (busy),
    .err_cnt     (err_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
  logic [3:0] upd_acc;
  int         upd_cycles;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // TX monitor: chooses tx_ready for the coming edge and, when a transfer
  // will happen on that edge, compares the byte with the scoreboard.
  always @(negedge clk) begin : tx_mon
    logic r;
    if (!nrst) begin
      tx_ready = 1'b0;
    end else begin
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = 1'b0;
      endcase
      tx_ready = r;
      if (trig_upd != 4'b0000) begin
        upd_acc = upd_acc | trig_upd;
        upd_cycles++;
      end
      if (tx_valid && r) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_reply: got %0h expected no reply", tx_data);
        end else begin
          check("reply_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; the byte is taken on the following posedge and
  // the task returns at the negedge after it.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((busy || (exp_q.size() != 0)) && (k < 300)) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait expired busy=%0b pending=%0d expected idle", name,
               busy, exp_q.size());
    end
  endtask

  function automatic logic [31:0] trig_all();
    return {trigout_ch3, trigout_ch2, trigout_ch1, trigout_ch0};
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_trigout"}, trig_all(), 0);
    check({tag, "_trig_type"}, trig_type, 32'hFF);
    check({tag, "_trig_upd"}, trig_upd, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  pre;    // junk byte sent while idle, must be ignored
    logic [7:0]  chan;
    logic [7:0]  typ;
    logic [7:0]  val;
    int          nb;     // frame bytes sent including the header
    logic [7:0]  rply;
    logic [3:0]  upd;
    logic [31:0] trig;   // {ch3, ch2, ch1, ch0} after the frame
    logic [7:0]  ttype;
    logic [7:0]  err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [7:0] inj [4];
    int         bad;

    tbl[0] = '{8'h52, 8'h00, 8'h01, 8'hA5, 4, 8'h06, 4'b0001, 32'h000000A5, 8'hFD, 8'd0};
    tbl[1] = '{8'hAA, 8'h07, 8'h00, 8'h00, 2, 8'h15, 4'b0000, 32'h000000A5, 8'hFD, 8'd1};
    tbl[2] = '{8'h00, 8'h02, 8'h03, 8'h00, 3, 8'h15, 4'b0000, 32'h000000A5, 8'hFD, 8'd2};
    tbl[3] = '{8'h35, 8'h03, 8'h02, 8'h7F, 4, 8'h06, 4'b1000, 32'h7F0000A5, 8'hBD, 8'd2};
    tbl[4] = '{8'hFF, 8'h01, 8'h00, 8'h3C, 4, 8'h06, 4'b0010, 32'h7F003CA5, 8'hB1, 8'd2};
    tbl[5] = '{8'h54, 8'h02, 8'h02, 8'hFF, 4, 8'h06, 4'b0100, 32'h7FFF3CA5, 8'hA1, 8'd2};
    tbl[6] = '{8'h06, 8'h00, 8'h02, 8'h00, 4, 8'h06, 4'b0001, 32'h7FFF3C00, 8'hA2, 8'd2};
    tbl[7] = '{8'h15, 8'h04, 8'h00, 8'h00, 2, 8'h15, 4'b0000, 32'h7FFF3C00, 8'hA2, 8'd3};
    tbl[8] = '{8'h01, 8'h01, 8'hFF, 8'h00, 3, 8'h15, 4'b0000, 32'h7FFF3C00, 8'hA2, 8'd4};

    nrst       = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    tx_ready   = 1'b0;
    upd_acc    = 4'b0000;
    upd_cycles = 0;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    nrst = 1'b1;
    @(negedge clk);

    // ---- table-driven frames ----
    rdy_mode = 1;
    for (int i = 0; i < 9; i++) begin
      upd_acc    = 4'b0000;
      upd_cycles = 0;
      send_byte(tbl[i].pre);
      exp_q.push_back(tbl[i].rply);
      send_byte(8'h53);
      send_byte(tbl[i].chan);
      if (tbl[i].nb >= 3) send_byte(tbl[i].typ);
      if (tbl[i].nb >= 4) send_byte(tbl[i].val);
      wait_done($sformatf("row%0d_done", i));
      check($sformatf("row%0d_trigout", i), trig_all(), tbl[i].trig);
      check($sformatf("row%0d_trig_type", i), trig_type, tbl[i].ttype);
      check($sformatf("row%0d_err_cnt", i), err_cnt, tbl[i].err);
      check($sformatf("row%0d_upd_mask", i), upd_acc, tbl[i].upd);
      check($sformatf("row%0d_upd_cycles", i), upd_cycles,
            (tbl[i].upd != 4'b0000) ? 1 : 0);
      check($sformatf("row%0d_tx_valid", i), tx_valid, 0);
    end

    // ---- update latency, then a 50-cycle stalled reply with injected bytes ----
    rdy_mode = 2;
    send_byte(8'h53);
    send_byte(8'h02);
    send_byte(8'h01);
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check("lat_trig_upd", trig_upd, 4'b0100);
    check("lat_ch2", trigout_ch2, 8'h5A);
    check("lat_trig_type", trig_type, 8'h92);
    check("lat_tx_valid", tx_valid, 1);
    check("lat_tx_data", tx_data, 8'h06);
    @(negedge clk);
    check("lat_upd_clear", trig_upd, 0);

    inj[0] = 8'h53; inj[1] = 8'h00; inj[2] = 8'h00; inj[3] = 8'h11;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      if ((c >= 10) && (c < 14)) begin
        rx_data  = inj[c-10];
        rx_valid = 1'b1;
      end
      @(negedge clk);
      rx_valid = 1'b0;
      if (!tx_valid || (tx_data !== 8'h06)) bad++;
    end
    check("stall_stable_cycles_bad", bad, 0);
    check("stall_ch0", trigout_ch0, 8'h00);
    exp_q.push_back(8'h06);
    rdy_mode = 1;
    wait_done("stall_done");
    check("stall_after_trigout", trig_all(), 32'h7F5A3C00);
    check("stall_after_err", err_cnt, 8'd4);

    // ---- back-to-back: header on the cycle right after leaving RESP ----
    rdy_mode = 0;
    exp_q.push_back(8'h15);
    send_byte(8'h53);
    send_byte(8'h01);
    send_byte(8'h03);
    @(negedge clk);
    exp_q.push_back(8'h06);
    send_byte(8'h53);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h44);
    wait_done("b2b_done");
    check("b2b_trigout", trig_all(), 32'h7F5A4400);
    check("b2b_trig_type", trig_type, 8'h96);
    check("b2b_err", err_cnt, 8'd5);

    // ---- timeout: expires exactly TO idle cycles after the last byte ----
    rdy_mode = 1;
    send_byte(8'h53);
    send_byte(8'h01);
    repeat (TO - 1) @(negedge clk);
    check("to_busy_before", busy, 1);
    @(negedge clk);
    check("to_busy_after", busy, 0);
    check("to_err", err_cnt, 8'd6);
    check("to_tx_valid", tx_valid, 0);
    check("to_trigout", trig_all(), 32'h7F5A4400);

    // ---- byte on the expiry edge wins; frame then completes ----
    send_byte(8'h53);
    repeat (TO - 1) @(negedge clk);
    exp_q.push_back(8'h06);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h21);
    wait_done("to_win_done");
    check("to_win_trigout", trig_all(), 32'h7F5A4421);
    check("to_win_err", err_cnt, 8'd6);
    check("to_win_trig_type", trig_type, 8'h96);

    // ---- reset in the middle of a frame ----
    rdy_mode = 0;
    send_byte(8'h53);
    send_byte(8'h02);
    send_byte(8'h00);
    nrst = 1'b0;
    #1;
    check_reset_vals("rst_frame");
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    send_byte(8'h77);
    repeat (5) @(negedge clk);
    check("rst_frame_no_reply", tx_valid, 0);
    check("rst_frame_trigout", trig_all(), 0);

    // ---- reset while the reply is pending ----
    rdy_mode = 2;
    send_byte(8'h53);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h12);
    @(negedge clk);
    check("rst_ack_pending", tx_valid, 1);
    nrst = 1'b0;
    #1;
    check_reset_vals("rst_ack");
    @(negedge clk);
    nrst = 1'b1;
    rdy_mode = 0;
    repeat (5) @(negedge clk);
    check("rst_ack_no_reply", tx_valid, 0);

    // ---- err_cnt saturation over 300 rejected frames ----
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back(8'h15);
      send_byte(8'h53);
      send_byte(8'($urandom_range(4, 255)));
      wait_done("sat_done");
      if (i == 253) check("sat_err_fe", err_cnt, 8'hFE);
      if (i == 254) check("sat_err_ff", err_cnt, 8'hFF);
    end
    check("sat_err_final", err_cnt, 8'hFF);
    check("sat_trigout", trig_all(), 0);
    check("sat_trig_type", trig_type, 8'hFF);
    check("final_pending_replies", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
